// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: drains the async FIFO read port into a valid/ready stream via a 3-entry skid buffer.
// Define AFIFO_RD_STATS_EN to build the pop/stall statistics counters; otherwise they read as 0.
module afifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  read_clock,
    input  logic                  read_reset,
    input  logic                  empty,
    output logic                  read_en,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  enable,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [2:0]            credit_used;
    logic                  capture;
    logic                  handshake;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts words already buffered plus the one still coming back from the FIFO,
    // so a pop is only issued when its data is guaranteed a free slot.
    always_comb begin
        credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
        read_en     = !read_reset && enable && !empty && !flush && (credit_used < 3'd3);
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf_q[rd_ptr_q];
    assign capture   = inflight_q && !flush;
    assign handshake = out_valid && out_ready && !flush;

    always_comb begin
        occ_d    = occ_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            occ_d    = 2'd0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
        end else begin
            if (capture) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (handshake) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (capture && !handshake) begin
                occ_d = occ_q + 2'd1;
            end else if (!capture && handshake) begin
                occ_d = occ_q - 2'd1;
            end
        end
    end

    always_ff @(posedge read_clock) begin
        if (read_reset) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= read_en;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Entries are cleared on reset so out_data reads 0 out of reset.
    always_ff @(posedge read_clock) begin
        if (read_reset) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else if (capture) begin
            buf_q[wr_ptr_q] <= read_data;
        end
    end

`ifdef AFIFO_RD_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] pop_count_q;
    logic [CNT_WIDTH-1:0] stall_count_q;

    always_ff @(posedge read_clock) begin
        if (read_reset) begin
            pop_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            if (read_en) begin
                pop_count_q <= pop_count_q + CntOne;
            end
            if (out_valid && !out_ready && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CntOne;
            end
        end
    end

    assign pop_count   = pop_count_q;
    assign stall_count = stall_count_q;
`else
    assign pop_count   = '0;
    assign stall_count = '0;
`endif

endmodule
